// File: rtl/mux_de_control.sv
// Registered symbol selector: picks one of ten WIDTH-bit symbols by CONTROL code,
// flags control (K) symbols and out-of-range codes, with one cycle of latency.
module mux_de_control #(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       CONTROL,
  input  logic             VALID,
  input  logic [WIDTH-1:0] COM,
  input  logic [WIDTH-1:0] PAD,
  input  logic [WIDTH-1:0] SKP,
  input  logic [WIDTH-1:0] STP,
  input  logic [WIDTH-1:0] SDP,
  input  logic [WIDTH-1:0] END,
  input  logic [WIDTH-1:0] EDB,
  input  logic [WIDTH-1:0] FTS,
  input  logic [WIDTH-1:0] IDL,
  input  logic [WIDTH-1:0] DATA,
  input  logic             CLK,
  input  logic             RESET,
  output logic [WIDTH-1:0] OUT,
  output logic             VALID_OUT,
  output logic             K_OUT,
  output logic             ERR
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q;
  logic             k_q, k_d;
  logic             err_q, err_d;

  always_comb begin
    // NOTE: defaults first so every path assigns every signal; no latches.
    out_d = out_q;
    k_d   = k_q;
    err_d = 1'b0;
    if (VALID) begin
      k_d = 1'b1;
      unique case (CONTROL)
        4'd0:    out_d = COM;
        4'd1:    out_d = PAD;
        4'd2:    out_d = SKP;
        4'd3:    out_d = STP;
        4'd4:    out_d = SDP;
        4'd5:    out_d = END;
        4'd6:    out_d = EDB;
        4'd7:    out_d = FTS;
        4'd8:    out_d = IDL;
        4'd9: begin
          out_d = DATA;
          k_d   = 1'b0;
        end
        default: begin
          // Illegal code: substitute idle and raise a one-cycle error.
          out_d = IDL;
          err_d = 1'b1;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      k_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= VALID;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  assign OUT       = out_q;
  assign VALID_OUT = valid_q;
  assign K_OUT     = k_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_mux_de_control.sv
// Directed bench for mux_de_control: expectations are queued when stimulus is
// applied and compared after the following rising edge.
module tb_mux_de_control;

  localparam int WIDTH = 8;

  logic [3:0]       CONTROL;
  logic             VALID;
  logic [WIDTH-1:0] COM, PAD, SKP, STP, SDP, END, EDB, FTS, IDL, DATA;
  logic             CLK;
  logic             RESET;
  logic [WIDTH-1:0] OUT;
  logic             VALID_OUT, K_OUT, ERR;

  mux_de_control #(.WIDTH(WIDTH)) dut (
    .CONTROL(CONTROL), .VALID(VALID),
    .COM(COM), .PAD(PAD), .SKP(SKP), .STP(STP), .SDP(SDP),
    .END(END), .EDB(EDB), .FTS(FTS), .IDL(IDL), .DATA(DATA),
    .CLK(CLK), .RESET(RESET),
    .OUT(OUT), .VALID_OUT(VALID_OUT), .K_OUT(K_OUT), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             vout;
    logic             k;
    logic             err;
    string            tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: what OUT and K_OUT should currently hold.
  logic [WIDTH-1:0] mdl_out = '0;
  logic             mdl_k   = 1'b0;

  function automatic logic [WIDTH-1:0] sym(input logic [3:0] c);
    case (c)
      4'd0: return COM;
      4'd1: return PAD;
      4'd2: return SKP;
      4'd3: return STP;
      4'd4: return SDP;
      4'd5: return END;
      4'd6: return EDB;
      4'd7: return FTS;
      4'd8: return IDL;
      4'd9: return DATA;
      default: return IDL;
    endcase
  endfunction

  task automatic check(input string tag, input string field,
                       input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s.%s: observed %h expected %h", tag, field, got, want);
    end
  endtask

  // Apply one cycle of stimulus, queue its expectation, then compare after the edge.
  task automatic step(input logic rst, input logic v, input logic [3:0] c,
                      input string tag);
    exp_t e;
    @(negedge CLK);
    RESET   = rst;
    VALID   = v;
    CONTROL = c;
    e.tag = tag;
    if (rst) begin
      mdl_out = '0;
      mdl_k   = 1'b0;
      e.vout  = 1'b0;
      e.err   = 1'b0;
    end else begin
      e.vout = v;
      e.err  = 1'b0;
      if (v) begin
        mdl_out = sym(c);
        mdl_k   = (c != 4'd9);
        e.err   = (c > 4'd9);
      end
    end
    e.out = mdl_out;
    e.k   = mdl_k;
    exp_q.push_back(e);

    @(posedge CLK);
    #1;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s.queue: observed empty expected entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, "OUT",       OUT,                  e.out);
      check(e.tag, "VALID_OUT", {7'd0, VALID_OUT},    {7'd0, e.vout});
      check(e.tag, "K_OUT",     {7'd0, K_OUT},        {7'd0, e.k});
      check(e.tag, "ERR",       {7'd0, ERR},          {7'd0, e.err});
    end
  endtask

  initial begin
    COM = 8'hBC; PAD = 8'hF7; SKP = 8'h1C; STP = 8'hFB; SDP = 8'h5C;
    END = 8'hFD; EDB = 8'hFE; FTS = 8'h3C; IDL = 8'h7C; DATA = 8'hFF;
    RESET = 1'b1; VALID = 1'b1; CONTROL = 4'd0;

    // Reset held two cycles with a valid code present: reset wins.
    step(1'b1, 1'b1, 4'd0, "rst0");
    step(1'b1, 1'b1, 4'd0, "rst1");

    // Every legal code back to back, first right after reset release.
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 4'(i), $sformatf("seq%0d", i));

    // One valid END then three idle cycles: OUT holds FD.
    step(1'b0, 1'b1, 4'd5, "hold_set");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 4'd0, $sformatf("hold%0d", i));

    // Out-of-range code, then a legal one clears ERR.
    step(1'b0, 1'b1, 4'd12, "bad12");
    step(1'b0, 1'b1, 4'd3,  "after_bad");
    step(1'b0, 1'b1, 4'd15, "bad15");
    step(1'b0, 1'b0, 4'd15, "bad_idle");

    // Streaming DATA with a one-cycle reset pulse mid-stream.
    step(1'b0, 1'b1, 4'd9, "strm0");
    step(1'b0, 1'b1, 4'd9, "strm1");
    step(1'b1, 1'b1, 4'd9, "strm_rst");
    step(1'b0, 1'b1, 4'd9, "strm_resume");
    step(1'b0, 1'b1, 4'd9, "strm2");

    // DATA changes while code 9 is held: OUT tracks one cycle later.
    @(negedge CLK);
    DATA = 8'hA5;
    step(1'b0, 1'b1, 4'd9, "data_a5");
    step(1'b0, 1'b1, 4'd9, "data_a5b");
    DATA = 8'h3A;
    step(1'b0, 1'b1, 4'd9, "data_3a");
    step(1'b0, 1'b1, 4'd8, "idl_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_de_control.md
MUX_DE_CONTROL -- requirements
Module: mux_de_control

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 8, the symbol width in bits; all symbol inputs and OUT SHALL be WIDTH bits, and verification SHALL use WIDTH=8 only.

Ports (name  direction  width  meaning):
REQ-002 The block SHALL have port CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port RESET  input  1  reset, synchronous and active-high, sampled on the CLK rising edge.
REQ-004 The block SHALL have port CONTROL  input  4  symbol select code.
REQ-005 The block SHALL have port VALID  input  1  qualifies CONTROL in the current cycle.
REQ-006 The block SHALL have the following symbol inputs, all input, WIDTH bits, selected by the CONTROL code shown; in verification they SHALL be tied to the value shown:
  - COM, code 0, 8'hBC
  - PAD, code 1, 8'hF7
  - SKP, code 2, 8'h1C
  - STP, code 3, 8'hFB
  - SDP, code 4, 8'h5C
  - END, code 5, 8'hFD
  - EDB, code 6, 8'hFE
  - FTS, code 7, 8'h3C
  - IDL, code 8, 8'h7C
  - DATA, code 9, 8'hFF
REQ-007 The block SHALL have port OUT  output  WIDTH  registered selected symbol.
REQ-008 The block SHALL have port VALID_OUT  output  1  registered copy of VALID.
REQ-009 The block SHALL have port K_OUT  output  1  registered flag, 1 when OUT holds a control (K) symbol, i.e. codes 0-8.
REQ-010 The block SHALL have port ERR  output  1  registered flag, 1 when a valid CONTROL code is out of range (10-15).
REQ-011 Ports SHALL appear in this order: CONTROL, VALID, COM, PAD, SKP, STP, SDP, END, EDB, FTS, IDL, DATA, CLK, RESET, OUT, VALID_OUT, K_OUT, ERR.

Function
REQ-012 All outputs SHALL be registered: an input sampled at rising edge n SHALL appear on the outputs after edge n, giving 1-cycle latency.
REQ-013 When VALID=1 and CONTROL is 0-9, on the next edge OUT SHALL take the value of the symbol input mapped to that code in REQ-006.
REQ-014 When VALID=1 and CONTROL is 0-8, K_OUT SHALL be 1; when CONTROL is 9, K_OUT SHALL be 0.
REQ-015 When VALID=1 and CONTROL is 0-9, ERR SHALL be 0.
REQ-016 When VALID=1 and CONTROL is 10-15, OUT SHALL take the IDL input value, K_OUT SHALL be 1 and ERR SHALL be 1, for that cycle only.
REQ-017 When VALID=0, OUT and K_OUT SHALL hold their previous values, ERR SHALL be 0, and CONTROL SHALL be ignored.
REQ-018 VALID_OUT SHALL equal VALID delayed by one cycle whenever RESET=0.
REQ-019 Symbol inputs SHALL be sampled at the same edge as CONTROL, so a change on a symbol input is visible on OUT one cycle later.
REQ-020 Back-to-back valid codes SHALL produce a new OUT value every cycle, with no bubbles.
REQ-021 The datapath SHALL be a pure selection: no arithmetic, no encoding, no bit reordering of symbol values.

Reset
REQ-022 While RESET=1 at a rising edge, the following SHALL hold after that edge: OUT=0, VALID_OUT=0, K_OUT=0, ERR=0.
REQ-023 RESET SHALL take priority over VALID and CONTROL in the same cycle.
REQ-024 After RESET deasserts, the first valid code SHALL appear on OUT one cycle later.
REQ-025 RESET asserted mid-stream SHALL clear the outputs at the next edge, with no residual state.

Verification
REQ-026 Scenario 1: RESET=1 for 2 cycles with VALID=1, CONTROL=0 -> OUT=8'h00, VALID_OUT=0, K_OUT=0, ERR=0.
REQ-027 Scenario 2: VALID=1, CONTROL stepped 0..9 on consecutive cycles -> OUT = BC, F7, 1C, FB, 5C, FD, FE, 3C, 7C, FF one cycle later each; K_OUT=1 for the first nine values and 0 for FF; VALID_OUT=1.
REQ-028 Scenario 3: VALID=1, CONTROL=5 for one cycle, then VALID=0 with CONTROL=0 for 3 cycles -> OUT holds 8'hFD, VALID_OUT=0, ERR=0.
REQ-029 Scenario 4: VALID=1, CONTROL=12 -> OUT=8'h7C, K_OUT=1, ERR=1 for one cycle; a following CONTROL=3 -> OUT=8'hFB, ERR=0.
REQ-030 Scenario 5: streaming CONTROL=9 with RESET pulsed high for 1 cycle -> outputs go to 0 after the reset edge; OUT=8'hFF resumes one cycle after RESET drops.
REQ-031 Scenario 6: DATA input changed from 8'hFF to 8'hA5 while CONTROL=9 held -> OUT follows with 1-cycle latency and K_OUT stays 0.
